// File: rtl/output_display.sv
// output_display
//   Converts an 18-bit binary word to six decimal digits by double-dabble and
//   drives six active-low seven-segment displays.
//   A CPU output instruction holds input_enable high. The block stalls the CPU
//   through halt_from_output until the conversion reaches its final cycle.
//
//   Ports
//     clock            sole clock, rising edge
//     reset            asynchronous, active-low
//     input_enable     output-instruction strobe, level-held
//     value[17:0]      word to display, sampled when a conversion starts
//     halt_from_output CPU stall request (combinational)
//     digit0..digit5   segment codes, digit0 least significant, bit0=a .. bit6=g
//
//   state | meaning
//   IDLE  | waiting for input_enable; the displays hold the last result
//   SHIFT | one double-dabble step per cycle, 18 cycles in total
//   DONE  | conversion complete; halt released; displays load on exit
module output_display #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_enable,
  input  logic [17:0] value,
  output logic        halt_from_output,
  output logic [6:0]  digit0,
  output logic [6:0]  digit1,
  output logic [6:0]  digit2,
  output logic [6:0]  digit3,
  output logic [6:0]  digit4,
  output logic [6:0]  digit5
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [4:0] N_BITS    = 5'd18;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [17:0]       shift_q, shift_d;
  logic [23:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0][6:0]   disp_q, disp_d;

  logic [23:0]       bcd_adj;
  logic [5:0][6:0]   seg_new;
  logic              lead_zero;
  logic [3:0]        nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Segment codes for the finished result. Scanning from the top digit down,
  // zeros stay blank until the first non-zero digit; digit0 always shows.
  always_comb begin
    seg_new   = '0;
    lead_zero = 1'b1;
    nib       = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      if (BLANK_LEADING && (i != 0) && lead_zero && (nib == 4'd0)) begin
        seg_new[i] = SEG_BLANK;
      end else begin
        seg_new[i] = seg7(nib);
        lead_zero  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (input_enable) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = N_BITS;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // {bcd, shift} << 1 after correction; the top BCD bit cannot be set
        // for an 18-bit input, so dropping it loses nothing.
        bcd_d   = {bcd_adj[22:0], shift_q[17]};
        shift_d = {shift_q[16:0], 1'b0};
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = seg_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Gated by reset so the CPU is never stalled while the block is held in reset.
  assign halt_from_output = reset & input_enable & (state_q != DONE);

  assign digit0 = disp_q[0];
  assign digit1 = disp_q[1];
  assign digit2 = disp_q[2];
  assign digit3 = disp_q[3];
  assign digit4 = disp_q[4];
  assign digit5 = disp_q[5];

endmodule

// File: tb/tb_output_display.sv
// Testbench for output_display: a timeline model predicts halt and all digits
// of two instances (leading blanking on and off) every cycle, plus literal
// expectations taken straight from the segment table.
module tb_output_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clock;
  logic        reset;
  logic        input_enable;
  logic [17:0] value;
  logic        halt_bl, halt_nb;
  logic [6:0]  bl [6];
  logic [6:0]  nb [6];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state
  bit          m_act = 1'b0;
  int          m_age = 0;
  int          m_val = 0;
  logic [6:0]  exp_bl [6];
  logic [6:0]  exp_nb [6];

  output_display #(.BLANK_LEADING(1'b1)) u_dut (
    .clock(clock), .reset(reset), .input_enable(input_enable), .value(value),
    .halt_from_output(halt_bl),
    .digit0(bl[0]), .digit1(bl[1]), .digit2(bl[2]),
    .digit3(bl[3]), .digit4(bl[4]), .digit5(bl[5])
  );

  output_display #(.BLANK_LEADING(1'b0)) u_dut_nb (
    .clock(clock), .reset(reset), .input_enable(input_enable), .value(value),
    .halt_from_output(halt_nb),
    .digit0(nb[0]), .digit1(nb[1]), .digit2(nb[2]),
    .digit3(nb[3]), .digit4(nb[4]), .digit5(nb[5])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return S0;  1: return S1;  2: return S2;  3: return S3;  4: return S4;
      5: return S5;  6: return S6;  7: return S7;  8: return S8;  9: return S9;
      default: return SB;
    endcase
  endfunction

  // Decimal digit i of v, blanked when the number has fewer than i+1 digits.
  function automatic logic [6:0] digit_of(input int v, input int i, input bit blank);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (blank && (i > 0) && (v < p)) return SB;
    return seg_of((v / p) % 10);
  endfunction

  // One mid-cycle model step: predict, compare, then advance past the next edge.
  task automatic model_check();
    logic exp_halt;
    if (!reset) begin
      m_act = 1'b0;
      m_age = 0;
      for (int i = 0; i < 6; i++) begin
        exp_bl[i] = (i == 0) ? S0 : SB;
        exp_nb[i] = (i == 0) ? S0 : SB;
      end
      exp_halt = 1'b0;
    end else begin
      if (!m_act && input_enable) begin
        m_act = 1'b1;
        m_age = 0;
        m_val = int'(value);
      end
      exp_halt = input_enable && !(m_act && m_age == 19);
    end
    chk("halt_bl", {31'd0, halt_bl}, {31'd0, exp_halt});
    chk("halt_nb", {31'd0, halt_nb}, {31'd0, exp_halt});
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bl_digit%0d", i), {25'd0, bl[i]}, {25'd0, exp_bl[i]});
      chk($sformatf("nb_digit%0d", i), {25'd0, nb[i]}, {25'd0, exp_nb[i]});
    end
    if (reset && m_act) begin
      m_age++;
      if (m_age == 20) begin
        m_act = 1'b0;
        for (int i = 0; i < 6; i++) begin
          exp_bl[i] = digit_of(m_val, i, 1'b1);
          exp_nb[i] = digit_of(m_val, i, 1'b0);
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    model_check();
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      settle();
      adv();
    end
  endtask

  // Single conversion with enable dropped in the DONE cycle; returns in
  // cycle 20 after its compare so the caller can add literal checks.
  task automatic conv(input int v);
    value        = v[17:0];
    input_enable = 1'b1;
    run(18);
    settle();
    chk("halt_cycle18", {31'd0, halt_bl}, 32'd1);
    adv();
    settle();
    chk("halt_cycle19", {31'd0, halt_bl}, 32'd0);
    input_enable = 1'b0;
    adv();
    settle();
  endtask

  initial begin
    reset        = 1'b0;
    input_enable = 1'b0;
    value        = '0;
    for (int i = 0; i < 6; i++) begin
      exp_bl[i] = (i == 0) ? S0 : SB;
      exp_nb[i] = (i == 0) ? S0 : SB;
    end

    settle();
    chk("rst_halt", {31'd0, halt_bl}, 32'd0);
    chk("rst_bl0", {25'd0, bl[0]}, {25'd0, S0});
    chk("rst_bl5", {25'd0, bl[5]}, {25'd0, SB});
    chk("rst_nb3", {25'd0, nb[3]}, {25'd0, SB});
    adv();
    run(2);
    reset = 1'b1;
    run(2);

    // zero
    conv(0);
    chk("zero_d0", {25'd0, bl[0]}, {25'd0, S0});
    for (int i = 1; i < 6; i++) chk("zero_blank", {25'd0, bl[i]}, {25'd0, SB});
    adv();

    // maximum input
    conv(262143);
    chk("max_d5", {25'd0, bl[5]}, {25'd0, S2});
    chk("max_d4", {25'd0, bl[4]}, {25'd0, S6});
    chk("max_d3", {25'd0, bl[3]}, {25'd0, S2});
    chk("max_d2", {25'd0, bl[2]}, {25'd0, S1});
    chk("max_d1", {25'd0, bl[1]}, {25'd0, S4});
    chk("max_d0", {25'd0, bl[0]}, {25'd0, S3});
    adv();

    // back-to-back: 12345 then 7, enable held for cycles 0..39
    value        = 18'd12345;
    input_enable = 1'b1;
    settle();
    adv();
    value = 18'd7;
    run(18);
    settle();
    chk("b2b_halt19", {31'd0, halt_bl}, 32'd0);
    adv();
    settle();
    chk("b2b_d5", {25'd0, bl[5]}, {25'd0, SB});
    chk("b2b_d4", {25'd0, bl[4]}, {25'd0, S1});
    chk("b2b_d3", {25'd0, bl[3]}, {25'd0, S2});
    chk("b2b_d2", {25'd0, bl[2]}, {25'd0, S3});
    chk("b2b_d1", {25'd0, bl[1]}, {25'd0, S4});
    chk("b2b_d0", {25'd0, bl[0]}, {25'd0, S5});
    chk("b2b_halt20", {31'd0, halt_bl}, 32'd1);
    adv();
    run(18);
    settle();
    chk("b2b_halt39", {31'd0, halt_bl}, 32'd0);
    input_enable = 1'b0;
    adv();
    settle();
    chk("b2b_seven", {25'd0, bl[0]}, {25'd0, S7});
    for (int i = 1; i < 6; i++) chk("b2b_seven_blank", {25'd0, bl[i]}, {25'd0, SB});
    adv();

    // value changes mid-conversion
    value        = 18'd1000;
    input_enable = 1'b1;
    run(5);
    value = 18'd9;
    run(14);
    settle();
    input_enable = 1'b0;
    adv();
    settle();
    chk("chg_d3", {25'd0, bl[3]}, {25'd0, S1});
    chk("chg_d2", {25'd0, bl[2]}, {25'd0, S0});
    chk("chg_d0", {25'd0, bl[0]}, {25'd0, S0});
    chk("chg_d4", {25'd0, bl[4]}, {25'd0, SB});
    adv();
    run(3);

    // reset mid-conversion
    value        = 18'd555;
    input_enable = 1'b1;
    run(10);
    reset = 1'b0;
    settle();
    chk("abort_halt", {31'd0, halt_bl}, 32'd0);
    chk("abort_d0", {25'd0, bl[0]}, {25'd0, S0});
    chk("abort_d3", {25'd0, bl[3]}, {25'd0, SB});
    adv();
    settle();
    adv();
    reset        = 1'b1;
    input_enable = 1'b0;
    run(2);
    conv(42);
    chk("post_d1", {25'd0, bl[1]}, {25'd0, S4});
    chk("post_d0", {25'd0, bl[0]}, {25'd0, S2});
    chk("post_d2", {25'd0, bl[2]}, {25'd0, SB});
    chk("nb_d5", {25'd0, nb[5]}, {25'd0, S0});
    chk("nb_d2", {25'd0, nb[2]}, {25'd0, S0});
    chk("nb_d1", {25'd0, nb[1]}, {25'd0, S4});
    chk("nb_d0", {25'd0, nb[0]}, {25'd0, S2});
    adv();
    run(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 Parameter: BLANK_LEADING, default 1, 1 blanks leading zero digits and 0 shows all six digits.
REQ-002 Port: clock  input  1  sole clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: input_enable  input  1  CPU output-instruction strobe, level-held while the instruction is current.
REQ-005 Port: value  input  18  unsigned word to display, sampled when a conversion starts.
REQ-006 Port: halt_from_output  output  1  CPU stall request, combinational.
REQ-007 Port: digit0..digit5  output  7 each  seven-segment codes, digit0 least significant; bit0=a .. bit6=g; active-low.

Function
REQ-008 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-009 IDLE with input_enable=1 SHALL, at the clock edge:
- latch value into the shift register;
- clear the 24-bit BCD accumulator;
- load the iteration counter with 18;
- enter SHIFT.
REQ-010 IDLE with input_enable=0 SHALL remain in IDLE.
REQ-011 Each SHIFT cycle SHALL perform one double-dabble step:
- add 3 to every BCD nibble that is >=5;
- shift {bcd, shift register} left by 1;
- decrement the counter.
REQ-012 SHIFT SHALL last exactly 18 cycles and then enter DONE.
REQ-013 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-014 The edge leaving DONE SHALL load the display registers from the BCD result.
REQ-015 halt_from_output SHALL equal input_enable AND (state != DONE), forced to 0 while reset is low.
REQ-016 Latency: enable first seen in cycle 0; halt high in cycles 0..18; halt low in cycle 19 (DONE); new digits visible from cycle 20.
REQ-017 If input_enable is still 1 in the IDLE cycle after DONE, that SHALL start a new conversion; back-to-back output instructions each convert once.
REQ-018 A change of value or a drop of input_enable during SHIFT SHALL NOT affect the running conversion, which SHALL complete and update the displays.
REQ-019 Nibble-to-segment encoding, active-low, bit6..bit0 = g..a:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
- blank=1111111.
REQ-020 With BLANK_LEADING=1, every digit above the most significant non-zero digit SHALL be blank, and digit0 SHALL always show its numeral.
REQ-021 The maximum input 262143 SHALL produce six valid decimal digits with no overflow; BCD nibbles SHALL never exceed 9 after conversion.

Reset
REQ-022 Asserting reset low SHALL asynchronously:
- force state IDLE;
- clear the shift register, BCD accumulator and counter;
- set digit0=1000000 ("0") and digit1..digit5=1111111 (blank), irrespective of BLANK_LEADING.
REQ-023 Reset asserted mid-SHIFT SHALL abort the conversion without updating the displays.
REQ-024 After reset deasserts, the first edge with input_enable=1 SHALL start a fresh conversion per REQ-009.

Verification
REQ-025 value=0, enable held:
- halt=1 in cycles 0..18 and 0 in cycle 19;
- from cycle 20, digit0=1000000 and digit1..5 blank.
REQ-026 value=262143 -> digits5..0 show 2,6,2,1,4,3, i.e. 0100100, 0000010, 0100100, 1111001, 0011001, 0110000.
REQ-027 Enable held 40 cycles, value=12345 for the first conversion then 7 -> two conversions:
- 1,2,3,4,5 visible at cycle 20 with digit5 blank;
- "7" alone at cycle 40 with digit1..5 blank.
REQ-028 value=1000, then value changed to 9 at cycle 5 -> result 1,0,0,0 with digit4..5 blank; no restart.
REQ-029 reset pulsed low at cycle 10 of SHIFT -> the following apply:
- displays return to the reset values;
- halt=0 while reset is low;
- a subsequent enable with value=42 shows 4,2 after 20 cycles.
REQ-030 BLANK_LEADING=0, value=42 -> digits5..0 show 0,0,0,0,4,2.
